// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding and constants for the
// instruction-memory responder and its boot loader.
package imem_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM0,
    CSUM1,
    RUN
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
  localparam int          HDR_W       = 16;

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch port plus byte-serial loader port
// between the core/loader (master) and the responder (slave).
interface imem_responder_if;

  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic        core_hold;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_error;

  modport master (
    output fetch_req, fetch_addr,
    output load_start, load_valid, load_byte,
    input  instr, instr_valid, fetch_fault,
    input  core_hold, load_ready, load_error
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  load_start, load_valid, load_byte,
    output instr, instr_valid, fetch_fault,
    output core_hold, load_ready, load_error
  );

endinterface

// File: rtl/imem_byte_assembler.sv
// imem_byte_assembler: packs little-endian loader bytes into
// 32-bit words, strobing on the fourth byte.
module imem_byte_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_strobe
);

  logic [1:0]  byte_idx;
  logic [23:0] shift;

  // Earlier bytes sit in the low lanes; the live byte is the MSB.
  assign word        = {byte_in, shift};
  assign word_strobe = byte_en && !clear
                    && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      byte_idx <= '0;
      shift    <= '0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
      shift    <= {byte_in, shift[23:8]};
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: boot-loaded instruction memory with 1-cycle
// fetch. Define IMEM_CHECKSUM_EN to require a trailing 16-bit sum.
import imem_pkg::*;

module imem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
  input logic             clk,
  input logic             reset_n,
  imem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [HDR_W:0] DEPTH_L =
    (HDR_W+1)'(DEPTH_WORDS);

  state_t             state, state_nxt;
  logic [HDR_W-1:0]   n_words, word_idx;
  logic [31:0]        word;
  logic [31:0]        mem [DEPTH_WORDS];
  logic               acc, byte_en, word_strobe;
  logic               in_range, last_word, hdr_zero;
  logic               we, run, fault;
  logic [31:0]        instr_q;
  logic               valid_q, fault_q;
  logic               hold_q, ready_q, error_q;

`ifdef IMEM_CHECKSUM_EN
  localparam state_t DATA_END = CSUM0;
  logic [15:0] csum;
  logic [7:0]  cs_lo;
  logic        cs_ok;
  assign cs_ok = ({bus.load_byte, cs_lo} == csum);
`else
  localparam state_t DATA_END = RUN;
`endif

  assign acc       = bus.load_valid && ready_q;
  assign byte_en   = reset_n && acc && (state == DATA);
  assign in_range  = ({1'b0, word_idx} < DEPTH_L);
  assign last_word = (word_idx == n_words - HDR_W'(1));
  assign hdr_zero  = ({bus.load_byte, n_words[7:0]} == '0);
  assign we        = reset_n && word_strobe && in_range;
  assign run       = (state == RUN);
  assign fault     = (|bus.fetch_addr[1:0])
                  || (|bus.fetch_addr[31:AW+2]);

  imem_byte_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (bus.load_start),
    .byte_en    (byte_en),
    .byte_in    (bus.load_byte),
    .word       (word),
    .word_strobe(word_strobe)
  );

  always_comb begin
    state_nxt = state;
    if (bus.load_start) begin
      state_nxt = HDR0;
    end else if (acc) begin
      case (state)
        HDR0: state_nxt = HDR1;
        HDR1: state_nxt = hdr_zero ? DATA_END : DATA;
        DATA: if (word_strobe && last_word)
                state_nxt = DATA_END;
`ifdef IMEM_CHECKSUM_EN
        CSUM0: state_nxt = CSUM1;
        CSUM1: state_nxt = cs_ok ? RUN : HDR0;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= HDR0;
      hold_q   <= 1'b1;
      ready_q  <= 1'b1;
      error_q  <= 1'b0;
      n_words  <= '0;
      word_idx <= '0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum     <= '0;
      cs_lo    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      hold_q  <= (state_nxt != RUN);
      ready_q <= (state_nxt != RUN);
      if (bus.load_start) begin
        error_q  <= 1'b0;
        n_words  <= '0;
        word_idx <= '0;
`ifdef IMEM_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (acc) begin
        case (state)
          HDR0: begin
            n_words[7:0] <= bus.load_byte;
            word_idx     <= '0;
`ifdef IMEM_CHECKSUM_EN
            csum         <= '0;
`endif
          end
          HDR1: n_words[15:8] <= bus.load_byte;
          DATA: begin
`ifdef IMEM_CHECKSUM_EN
            csum <= csum + 16'(bus.load_byte);
`endif
            if (word_strobe) begin
              word_idx <= word_idx + HDR_W'(1);
              if (!in_range) error_q <= 1'b1;
            end
          end
`ifdef IMEM_CHECKSUM_EN
          CSUM0: cs_lo <= bus.load_byte;
          CSUM1: if (!cs_ok) error_q <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (run && bus.fetch_req) begin
        valid_q <= 1'b1;
        fault_q <= fault;
        instr_q <= fault ? NOP_INSTR
                 : mem[bus.fetch_addr[AW+1:2]];
      end else begin
        valid_q <= 1'b0;
        fault_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

  // Storage is deliberately unreset so a reset mid-load keeps contents.
  always_ff @(posedge clk) begin
    if (we) mem[word_idx[AW-1:0]] <= word;
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.core_hold   = hold_q;
  assign bus.load_ready  = ready_q;
  assign bus.load_error  = error_q;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the far end of the fetch interface driven by the program counter. It accepts byte addresses, returns the addressed 32-bit instruction one cycle later, and flags misaligned or out-of-range fetches. A byte-serial boot loader fills the memory after reset or on request. The block holds the core while loading.

## Interface
Parameters:
- DEPTH_WORDS, 256: instruction words stored; power of two; address width AW = log2(DEPTH_WORDS).
- NOP_INSTR, 32'h0000_0013: instruction returned on faults and while not running.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
- fetch_req  in  1  fetch request from PC stage.
- fetch_addr  in  32  byte address of requested instruction.
- instr  out  32  registered instruction; reset value NOP_INSTR.
- instr_valid  out  1  instr is a response to a fetch accepted in RUN; reset 0.
- fetch_fault  out  1  accompanies instr_valid: misaligned or out of range; reset 0.
- core_hold  out  1  high whenever state is not RUN; reset 1.
- load_start  in  1  one-cycle pulse; restarts loader.
- load_valid  in  1  load_byte carries a byte.
- load_byte  in  8  loader byte stream.
- load_ready  out  1  loader accepts a byte this cycle; reset 1.
- load_error  out  1  sticky until next load_start/reset; reset 0.

## Operation
- Byte accepted iff load_valid && load_ready.
- Stream format: HDR0 = word count N[7:0], HDR1 = N[15:8], then 4N data bytes, little-endian per word, word 0 first.
- States: HDR0 -> HDR1 on accepted byte; HDR1 -> DATA on accepted byte, or -> RUN if N == 0; DATA -> RUN after the 4N-th byte; RUN -> HDR0 on load_start. load_start in any loading state -> HDR0, counters cleared, load_error cleared.
- load_ready = 1 in HDR0/HDR1/DATA, 0 in RUN.
- DATA: 2-bit byte_idx, 24-bit shift assembly; on 4th byte write word to mem[word_idx], word_idx++. Words with word_idx >= DEPTH_WORDS are discarded and set load_error; the stream is still consumed to completion.
- Fetch in RUN with fetch_req: next cycle instr_valid = 1; if fetch_addr[1:0] != 0 or fetch_addr[31:2] >= DEPTH_WORDS, then instr = NOP_INSTR and fetch_fault = 1; else instr = mem[fetch_addr[AW+1:2]] and fetch_fault = 0.
- fetch_req outside RUN is ignored: instr_valid = 0, instr = NOP_INSTR.
- Memory array has no reset; reset mid-load leaves partial contents and returns the FSM to HDR0.

## Timing
- Fetch latency exactly 1 cycle; back-to-back fetches are supported every cycle.
- A word write in cycle t is visible to a fetch issued in cycle t+1 or later.
- Transition to RUN occurs on the edge accepting the final byte; core_hold drops in the same cycle that state becomes RUN, and fetches are accepted from that cycle on.
- load_start and fetch_req in the same RUN cycle: the fetch completes normally, and the state enters HDR0 in the following cycle.

## Configuration
- IMEM_CHECKSUM_EN defined: two trailing bytes (CS0, CS1) follow the data, forming a 16-bit little-endian sum of all data bytes mod 2^16. States CSUM0 and CSUM1 are added. On mismatch, load_error = 1 and the FSM stays in HDR0 awaiting a new stream; it does not enter RUN. N == 0 still requires both checksum bytes, whose value must be 0.
- Undefined: no checksum states; behaviour is as in Operation.

## Structure
- imem_pkg: state enum (HDR0, HDR1, DATA, CSUM0, CSUM1, RUN), NOP_INSTR default constant, header width constant (16).
- Sub-module imem_byte_assembler: byte_idx counter and shift register. It emits word plus word_strobe on the 4th byte and clears on load_start/reset.

## Test plan
- Reset, stream N=2, words 32'h00500093, 32'h00A00113; fetch 0x0 then 0x4 -> instr matches each word one cycle after request, fetch_fault = 0, core_hold = 0 after the last byte.
- Fetch 0x2 and 0x400 (DEPTH 256) -> instr = 32'h00000013, fetch_fault = 1, instr_valid = 1.
- N=257 stream -> load_error = 1, mem[0..255] written, word 256 discarded, state RUN.
- load_start in RUN, then fetch_req -> instr_valid = 0, core_hold = 1, load_ready = 1.
- reset_n low after 5 data bytes, then a fresh N=1 stream -> word 0 holds the new value; no stale bytes are merged.
- IMEM_CHECKSUM_EN: N=1 word 32'h01020304, checksum 0x000A -> RUN; checksum 0x000B -> load_error = 1, core_hold stays 1.
